// File: rtl/stump_mem_responder_pkg.sv
//==============================================================================
// Module  : stump_mem_responder_pkg
// Brief   : Shared state encodings and constants for the Stump memory responder.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package stump_mem_responder_pkg;

    localparam int C_DATA_W = 16;
    localparam int C_ADDR_W = 16;
    localparam int C_CNT_W  = 4;

    localparam logic [C_DATA_W-1:0] C_INIT_VALUE = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } state_e;

    function automatic logic addr_in_range(input logic [C_ADDR_W-1:0] addr, input int depth);
        return (int'(addr) < depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stump_mem_array.sv
//==============================================================================
// Module  : stump_mem_array
// Brief   : MEM_DEPTH x 16 storage, synchronous write, asynchronous read.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module stump_mem_array
    import stump_mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    waddr_i,
    input  logic [C_DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]    raddr_i,
    output logic [C_DATA_W-1:0] rdata_o
);

    // Contents are deliberately not reset; software must initialise memory.
    logic [C_DATA_W-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/stump_mem_responder.sv
//==============================================================================
// Module  : stump_mem_responder
// Brief   : Word-addressed 16-bit RAM responder with programmable wait states.
//           Optional macro STUMP_MEM_RANGE_CHECK_EN flags and blocks addresses
//           at or beyond MEM_DEPTH instead of aliasing them.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module stump_mem_responder
    import stump_mem_responder_pkg::*;
#(
    parameter int                  MEM_DEPTH   = 1024,
    parameter int                  WAIT_STATES = 1,
    parameter logic [C_DATA_W-1:0] INIT_VALUE  = C_INIT_VALUE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [C_ADDR_W-1:0] addr,
    input  logic [C_DATA_W-1:0] wdata,
    output logic [C_DATA_W-1:0] rdata,
    output logic                ready,
    output logic                err
);

    localparam int                 C_IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [C_CNT_W-1:0] C_WAIT_LOAD = (WAIT_STATES > 0) ?
                                                 C_CNT_W'(WAIT_STATES - 1) : '0;

    state_e              state_q, state_d;
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [C_ADDR_W-1:0] addr_q, addr_d;
    logic [C_DATA_W-1:0] wdata_q, wdata_d;

    logic                w_ack;
    logic                w_oor;
    logic                w_we_int;
    logic [C_DATA_W-1:0] w_mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // The holding registers only load in IDLE, so bus changes mid-access are ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = C_WAIT_LOAD;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef STUMP_MEM_RANGE_CHECK_EN
    assign w_oor = !addr_in_range(addr_q, MEM_DEPTH);
`else
    assign w_oor = 1'b0;

    // Upper address bits are intentionally dropped so addresses alias modulo MEM_DEPTH.
    if (C_IDX_W < C_ADDR_W) begin : g_alias_hi
        logic w_unused_hi;
        assign w_unused_hi = ^addr_q[C_ADDR_W-1:C_IDX_W];
    end
`endif

    assign w_ack    = (state_q == ST_ACK);
    assign w_we_int = w_ack && we_q && !w_oor;

    stump_mem_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (C_IDX_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_we_int),
        .waddr_i (addr_q[C_IDX_W-1:0]),
        .wdata_i (wdata_q),
        .raddr_i (addr_q[C_IDX_W-1:0]),
        .rdata_o (w_mem_rdata)
    );

    assign ready = w_ack;
    assign err   = w_ack && w_oor;
    assign rdata = (w_ack && !we_q && !w_oor) ? w_mem_rdata : INIT_VALUE;

endmodule

`default_nettype wire

// File: tb/tb_stump_mem_responder.sv
//==============================================================================
// Module  : tb_stump_mem_responder
// Brief   : Scoreboard bench for two responder instances (1 and 0 wait states).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_stump_mem_responder;

    localparam logic [15:0] INIT    = 16'hC0DE;
    localparam int          DEPTH_A = 1024;
    localparam int          DEPTH_B = 64;
    localparam int          WS_A    = 1;
    localparam int          WS_B    = 0;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [15:0] addr_s  [2];
    logic [15:0] wdata_s [2];
    logic [15:0] rdata_s [2];
    logic        ready_s [2];
    logic        err_s   [2];

    always #5 clk = ~clk;

    stump_mem_responder #(.MEM_DEPTH(DEPTH_A), .WAIT_STATES(WS_A), .INIT_VALUE(INIT)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0]));

    stump_mem_responder #(.MEM_DEPTH(DEPTH_B), .WAIT_STATES(WS_B), .INIT_VALUE(INIT)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1]));

    typedef struct {
        int          rcyc;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] mdl_a [DEPTH_A];
    logic [15:0] mdl_b [DEPTH_B];
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ws_of(input int inst);
        return (inst == 0) ? WS_A : WS_B;
    endfunction

    function automatic int depth_of(input int inst);
        return (inst == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    // Reference: memory as a plain array indexed modulo depth; stores return INIT.
    task automatic expect_push(input int inst, input logic w, input logic [15:0] a,
                               input logic [15:0] d, input int rcyc);
        exp_t e;
        int   dep;
        int   idx;
        logic oor;
        dep    = depth_of(inst);
        idx    = int'(a) % dep;
        oor    = (int'(a) >= dep);
        e.rcyc = rcyc;
`ifdef STUMP_MEM_RANGE_CHECK_EN
        e.err  = oor;
`else
        e.err  = 1'b0;
        if (oor) idx = int'(a) % dep;
`endif
        if (w) begin
            e.rdata = INIT;
            if (!e.err) begin
                if (inst == 0) mdl_a[idx] = d;
                else           mdl_b[idx] = d;
            end
        end else if (e.err) begin
            e.rdata = INIT;
        end else begin
            e.rdata = (inst == 0) ? mdl_a[idx] : mdl_b[idx];
        end
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (ready_s[i] === 1'b1) begin
                    have = 1'b0;
                    if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    if (!have) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_ready dut%0d: got ready=1 expected 0 (cycle %0d)", i, cyc);
                    end else begin
                        chk($sformatf("latency_dut%0d", i), cyc, e.rcyc);
                        chk($sformatf("rdata_dut%0d", i), {16'h0, rdata_s[i]}, {16'h0, e.rdata});
                        chk($sformatf("err_dut%0d", i), {31'h0, err_s[i]}, {31'h0, e.err});
                    end
                end
            end
        end
    end

    // from_ack: called at the ACK negedge of a previous access with req still held.
    task automatic access(input int inst, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input bit from_ack, input bit keep);
        bit seen;
        req_s[inst]   = 1'b1;
        we_s[inst]    = w;
        addr_s[inst]  = a;
        wdata_s[inst] = d;
        expect_push(inst, w, a, d, cyc + (from_ack ? 2 : 1) + ws_of(inst));
        seen = 1'b0;
        for (int t = 1; t <= 50 && !seen; t++) begin
            @(negedge clk);
            if (ready_s[inst] === 1'b1) begin
                seen = 1'b1;
            end else if (t > (from_ack ? 1 : 0)) begin
                addr_s[inst]  = 16'($urandom);
                wdata_s[inst] = 16'($urandom);
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout dut%0d: got no ready expected ready within 50 cycles", inst);
        end
        if (!keep || !seen) begin
            req_s[inst] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic abort_store(input int inst, input logic [15:0] a, input logic [15:0] d);
        req_s[inst]   = 1'b1;
        we_s[inst]    = 1'b1;
        addr_s[inst]  = a;
        wdata_s[inst] = d;
        @(negedge clk);
        chk("abort_wait_ready", {31'h0, ready_s[inst]}, 32'h0);
        req_s[inst] = 1'b0;
        @(negedge clk);
        chk("abort_after_ready", {31'h0, ready_s[inst]}, 32'h0);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_ready%0d", tag, i), {31'h0, ready_s[i]}, 32'h0);
            chk($sformatf("%s_rdata%0d", tag, i), {16'h0, rdata_s[i]}, {16'h0, INIT});
            chk($sformatf("%s_err%0d", tag, i), {31'h0, err_s[i]}, 32'h0);
        end
    endtask

    initial begin
        bit keep_prev;
        bit keep_now;
        int lo;
        int hi;
        for (int i = 0; i < 2; i++) begin
            req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int a = 0; a < 32; a++) begin
            access(0, 1'b1, 16'(a), 16'($urandom), 1'b0, 1'b0);
            access(1, 1'b1, 16'(a), 16'($urandom), 1'b0, 1'b0);
        end

        access(0, 1'b1, 16'h0005, 16'h1234, 1'b0, 1'b0);
        access(0, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0);
        abort_store(0, 16'h0003, 16'hAAAA);
        access(0, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0);
        access(0, 1'b1, 16'h0401, 16'h0F0F, 1'b0, 1'b0);
        access(0, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0);
        access(0, 1'b1, 16'h0400, 16'h5555, 1'b0, 1'b0);
        access(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Reset lands in the WAIT cycle of a store; the store must be abandoned.
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 16'h0010; wdata_s[0] = 16'hBEEF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        req_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        access(0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);

        access(1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b1);
        access(1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b1);
        access(1, 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b0);
        access(1, 1'b1, 16'h0041, 16'h0F0F, 1'b0, 1'b0);
        access(1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0);

        for (int inst = 0; inst < 2; inst++) begin
            keep_prev = 1'b0;
            for (int k = 0; k < 40; k++) begin
                keep_now = (k < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
                lo = $urandom_range(0, 31);
                hi = $urandom_range(0, 3);
                access(inst, 1'($urandom_range(0, 1)),
                       16'((hi * depth_of(inst)) + lo), 16'($urandom), keep_prev, keep_now);
                keep_prev = keep_now;
            end
        end

        repeat (5) @(negedge clk);
        chk("pending_dut0", q0.size(), 32'h0);
        chk("pending_dut1", q1.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
